// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit carry-lookahead adder between NUM_REQ requesters,
// with a single-entry response register and completed/carry-out operation counters.
module cla_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  output logic [CNT_W-1:0]         op_count,
  output logic [CNT_W-1:0]         carry_count
);

  logic            slot_free;
  logic            gnt_any;
  logic            accept;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_ptr_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   sum;
  logic [3:0]       bg;
  logic [3:0]       bp;
  logic             bc;

  assign slot_free = !rsp_valid || rsp_ready;

  // Search starts at rr_ptr and wraps at NUM_REQ, which need not be a power of two.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
    end
    if (rst_n && slot_free && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_comb begin
    op_a = req_a[32'(gnt_idx) * WIDTH +: WIDTH];
    op_b = req_b[32'(gnt_idx) * WIDTH +: WIDTH];
  end

  // 4-bit lookahead groups; group carries ripple between groups.
  always_comb begin
    gen   = op_a & op_b;
    prop  = op_a ^ op_b;
    carry = '0;
    bg    = '0;
    bp    = '0;
    bc    = 1'b0;
    for (int unsigned blk = 0; blk < WIDTH / 4; blk++) begin
      bg = gen[4*blk +: 4];
      bp = prop[4*blk +: 4];
      bc = carry[4*blk];
      carry[4*blk+1] = bg[0] | (bp[0] & bc);
      carry[4*blk+2] = bg[1] | (bp[1] & bg[0]) | (&bp[1:0] & bc);
      carry[4*blk+3] = bg[2] | (bp[2] & bg[1]) | (&bp[2:1] & bg[0]) | (&bp[2:0] & bc);
      carry[4*blk+4] = bg[3] | (bp[3] & bg[2]) | (&bp[3:2] & bg[1]) | (&bp[3:1] & bg[0])
                     | (&bp & bc);
    end
    sum = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rr_ptr_q    <= '0;
      op_count    <= '0;
      carry_count <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_idx;
        rsp_sum   <= sum;
        rr_ptr_q  <= rr_ptr_d;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        op_count <= op_count + CNT_W'(1);
        if (rsp_sum[WIDTH]) begin
          carry_count <= carry_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Scoreboard bench for cla_adder_arbiter: directed grants push expected {id, sum} entries,
// and a negedge monitor pops and compares them on every response handshake.
module tb_cla_adder_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [64:0]  rsp_sum;
  logic [15:0]  op_count;
  logic [15:0]  carry_count;

  logic [3:0]   req_ready4;
  logic         rsp_valid4;
  logic [1:0]   rsp_id4;
  logic [64:0]  rsp_sum4;
  logic [3:0]   op_count4;
  logic [3:0]   carry_count4;

  logic [63:0]  a_op    [4];
  logic [63:0]  b_op    [4];
  logic [64:0]  exp_sum [4];
  logic [66:0]  sb [$];
  logic [66:0]  mon_exp;
  int           checks;
  int           errors;

  cla_adder_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .op_count    (op_count),
    .carry_count (carry_count)
  );

  cla_adder_arbiter #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready4),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid4),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id4),
    .rsp_sum     (rsp_sum4),
    .op_count    (op_count4),
    .carry_count (carry_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected response: got id %0d sum %h, expected none", rsp_id, rsp_sum);
      end else begin
        mon_exp = sb.pop_front();
        chk("rsp_id", 65'(rsp_id), 65'(mon_exp[66:65]));
        chk("rsp_sum", rsp_sum, mon_exp[64:0]);
      end
    end
  end

  // Drive one cycle, check the grant mid-cycle, and record the expected result of any accept.
  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                      input string nm);
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    chk({nm, " req_ready"}, 65'(req_ready), 65'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i] && v[i]) sb.push_back({2'(i), exp_sum[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_op[0] = 64'h0000_0000_0000_0001;  b_op[0] = 64'h0000_0000_0000_0002;
    a_op[1] = 64'h8000_0000_0000_0000;  b_op[1] = 64'h8000_0000_0000_0000;
    a_op[2] = 64'h0000_0F80_1000_0700;  b_op[2] = 64'h0040_02C0_C200_FC00;
    a_op[3] = 64'hFFFF_FFFF_FFFF_FFFF;  b_op[3] = 64'h0000_0000_0000_0001;
    exp_sum[0] = 65'h0_0000_0000_0000_0003;
    exp_sum[1] = 65'h1_0000_0000_0000_0000;
    exp_sum[2] = 65'h0_0040_1240_D201_0300;
    exp_sum[3] = 65'h1_0000_0000_0000_0000;
    for (int i = 0; i < 4; i++) begin
      req_a[i*64 +: 64] = a_op[i];
      req_b[i*64 +: 64] = b_op[i];
    end

    // Reset state, with requests pending to show req_ready stays low.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #3;
    chk("reset req_ready", 65'(req_ready), 65'(0));
    chk("reset rsp_valid", 65'(rsp_valid), 65'(0));
    chk("reset rsp_id", 65'(rsp_id), 65'(0));
    chk("reset rsp_sum", rsp_sum, 65'(0));
    chk("reset op_count", 65'(op_count), 65'(0));
    chk("reset carry_count", 65'(carry_count), 65'(0));
    do_reset();

    // Single request from requester 2.
    step(4'b0100, 1'b1, 4'b0100, "single");
    chk("single rsp_valid", 65'(rsp_valid), 65'(1));
    step(4'b0000, 1'b1, 4'b0000, "single drain");
    chk("single op_count", 65'(op_count), 65'(1));
    chk("single rsp_valid after drain", 65'(rsp_valid), 65'(0));

    // Round robin with all requesters valid.
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1, 4'(1 << (k % 4)), "rr");
    chk("rr op_count", 65'(op_count), 65'(4));
    chk("rr carry_count", 65'(carry_count), 65'(2));
    step(4'b0000, 1'b1, 4'b0000, "rr drain");

    // Backpressure holds the result and blocks all grants.
    do_reset();
    step(4'b0001, 1'b1, 4'b0001, "bp first");
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b1111;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp req_ready", 65'(req_ready), 65'(0));
      chk("bp rsp_valid", 65'(rsp_valid), 65'(1));
      chk("bp rsp_id", 65'(rsp_id), 65'(0));
      chk("bp rsp_sum", rsp_sum, exp_sum[0]);
      @(posedge clk);
      #1;
    end
    step(4'b1111, 1'b1, 4'b0010, "bp release");
    chk("bp new rsp_id", 65'(rsp_id), 65'(1));
    step(4'b0000, 1'b1, 4'b0000, "bp drain");
    chk("bp op_count", 65'(op_count), 65'(2));

    // Carry-out.
    do_reset();
    step(4'b1000, 1'b1, 4'b1000, "carry");
    chk("carry_count before handshake", 65'(carry_count), 65'(0));
    step(4'b0000, 1'b1, 4'b0000, "carry drain");
    chk("carry carry_count", 65'(carry_count), 65'(1));
    chk("carry op_count", 65'(op_count), 65'(1));

    // Asynchronous reset while a result is held.
    do_reset();
    step(4'b0001, 1'b1, 4'b0001, "midrst a");
    step(4'b0010, 1'b1, 4'b0010, "midrst b");
    chk("midrst op_count before", 65'(op_count), 65'(1));
    chk("midrst rsp_valid before", 65'(rsp_valid), 65'(1));
    req_valid = 4'b0000;
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst rsp_valid", 65'(rsp_valid), 65'(0));
    chk("midrst op_count", 65'(op_count), 65'(0));
    chk("midrst carry_count", 65'(carry_count), 65'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, "midrst first grant");
    step(4'b0000, 1'b1, 4'b0000, "midrst drain");

    // Counter wrap: 17 handshakes on the 4-bit counter build.
    do_reset();
    for (int k = 0; k < 17; k++) step(4'b1111, 1'b1, 4'(1 << (k % 4)), "wrap");
    step(4'b0000, 1'b1, 4'b0000, "wrap drain");
    chk("wrap op_count cnt16", 65'(op_count), 65'(17));
    chk("wrap carry_count cnt16", 65'(carry_count), 65'(8));
    chk("wrap op_count cnt4", 65'(op_count4), 65'(1));
    chk("wrap carry_count cnt4", 65'(carry_count4), 65'(8));

    chk("scoreboard empty", 65'(sb.size()), 65'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
